// File: rtl/csr_file_trap_if.sv
// Bundle between the writeback stage and the machine-mode CSR/trap unit.
// The master modport is the pipeline side and the slave modport is the CSR file.
interface csr_file_trap_if #(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 2
);
  localparam int HPM_W = (NUM_HPM < 1) ? 1 : NUM_HPM;

  logic [11:0]      ra;
  logic [XLEN-1:0]  rd;
  logic             rd_illegal;
  logic             wr_valid;
  logic [11:0]      wa;
  logic [XLEN-1:0]  wd;
  logic             trap_valid;
  logic             trap_is_int;
  logic [4:0]       trap_code;
  logic [XLEN-1:0]  trap_pc;
  logic [XLEN-1:0]  trap_tval;
  logic             mret_valid;
  logic [1:0]       instret_inc;
  logic [HPM_W-1:0] hpm_event;
  logic             irq_msip;
  logic             irq_mtip;
  logic             irq_meip;
  logic             int_req;
  logic [4:0]       int_code;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;

  modport master (
    output ra, wr_valid, wa, wd, trap_valid, trap_is_int, trap_code, trap_pc,
           trap_tval, mret_valid, instret_inc, hpm_event, irq_msip, irq_mtip, irq_meip,
    input  rd, rd_illegal, int_req, int_code, redirect_valid, redirect_pc
  );

  modport slave (
    input  ra, wr_valid, wa, wd, trap_valid, trap_is_int, trap_code, trap_pc,
           trap_tval, mret_valid, instret_inc, hpm_event, irq_msip, irq_mtip, irq_meip,
    output rd, rd_illegal, int_req, int_code, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file with trap entry, MRET return, interrupt arbitration,
// performance counters and a registered fetch redirect.
module csr_file_trap #(
  parameter int XLEN        = 64,
  parameter int NUM_HPM     = 2,
  parameter int VECTORED_EN = 1
) (
  input logic             clk,
  input logic             reset,
  csr_file_trap_if.slave  bus
);
  localparam int HPM_W = (NUM_HPM < 1) ? 1 : NUM_HPM;
  localparam logic [XLEN-1:0] ONE_C = {{(XLEN-1){1'b0}}, 1'b1};

  // mie/mip are stored compactly as {bit11, bit7, bit3}
  logic            mstatus_mie_r, mstatus_mpie_r;
  logic [1:0]      mstatus_fs_r;
  logic [2:0]      mie_r, mip_r;
  logic [XLEN-1:0] mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
  logic [XLEN-1:0] mcycle_r, minstret_r;
  logic [XLEN-1:0] hpm_r [HPM_W];
  logic            redirect_valid_r;
  logic [XLEN-1:0] redirect_pc_r;

  logic [XLEN-1:0] mstatus_s, rd_s, trap_target_s;
  logic            rd_illegal_s, hpm_hit_s, int_req_s;
  logic [4:0]      int_code_s;
  logic [2:0]      pend_s;

  function automatic logic [XLEN-1:0] irq_expand(input logic [2:0] b);
    logic [XLEN-1:0] r;
    r     = '0;
    r[11] = b[2];
    r[7]  = b[1];
    r[3]  = b[0];
    return r;
  endfunction

  function automatic logic [11:0] hpm_addr(input int idx);
    logic [11:0] off;
    off = idx[11:0];
    return 12'hB03 + off;
  endfunction

  // Assemble the architectural mstatus view; MPP is hardwired to machine mode
  always_comb begin
    mstatus_s            = '0;
    mstatus_s[XLEN-1]    = |mstatus_fs_r;
    mstatus_s[14:13]     = mstatus_fs_r;
    mstatus_s[12:11]     = 2'b11;
    mstatus_s[7]         = mstatus_mpie_r;
    mstatus_s[3]         = mstatus_mie_r;
  end

  // Combinational CSR read port
  always_comb begin
    rd_s         = '0;
    rd_illegal_s = 1'b0;
    hpm_hit_s    = 1'b0;
    for (int i = 0; i < HPM_W; i++) begin
      if (i < NUM_HPM && bus.ra == hpm_addr(i)) begin
        hpm_hit_s = 1'b1;
        rd_s      = hpm_r[i];
      end else begin
        hpm_hit_s = hpm_hit_s;
      end
    end
    case (bus.ra)
      12'h300: rd_s = mstatus_s;
      12'h301: rd_s = '0;
      12'h304: rd_s = irq_expand(mie_r);
      12'h305: rd_s = mtvec_r;
      12'h340: rd_s = mscratch_r;
      12'h341: rd_s = mepc_r;
      12'h342: rd_s = mcause_r;
      12'h343: rd_s = mtval_r;
      12'h344: rd_s = irq_expand(mip_r);
      12'hB00: rd_s = mcycle_r;
      12'hB02: rd_s = minstret_r;
      12'hF14: rd_s = '0;
      default: rd_illegal_s = ~hpm_hit_s;
    endcase
  end

  // Interrupt arbitration: external > software > timer
  always_comb begin
    pend_s    = mip_r & mie_r;
    int_req_s = mstatus_mie_r & (|pend_s);
    if (!int_req_s)     int_code_s = 5'd0;
    else if (pend_s[2]) int_code_s = 5'd11;
    else if (pend_s[0]) int_code_s = 5'd3;
    else                int_code_s = 5'd7;
  end

  // Trap target: vectored offset only applies to interrupts
  always_comb begin
    if (mtvec_r[0] && bus.trap_is_int)
      trap_target_s = {mtvec_r[XLEN-1:2], 2'b00} + {{(XLEN-7){1'b0}}, bus.trap_code, 2'b00};
    else
      trap_target_s = {mtvec_r[XLEN-1:2], 2'b00};
  end

  // CSR state, counters, trap/MRET sequencing and the redirect register
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_r    <= 1'b0;
      mstatus_mpie_r   <= 1'b0;
      mstatus_fs_r     <= 2'b00;
      mie_r            <= 3'b000;
      mip_r            <= 3'b000;
      mtvec_r          <= '0;
      mscratch_r       <= '0;
      mepc_r           <= '0;
      mcause_r         <= '0;
      mtval_r          <= '0;
      mcycle_r         <= '0;
      minstret_r       <= '0;
      for (int i = 0; i < HPM_W; i++) hpm_r[i] <= '0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      mip_r            <= {bus.irq_meip, bus.irq_mtip, bus.irq_msip};
      mcycle_r         <= mcycle_r + ONE_C;
      minstret_r       <= minstret_r + {{(XLEN-2){1'b0}}, bus.instret_inc};
      for (int i = 0; i < HPM_W; i++)
        if (i < NUM_HPM && bus.hpm_event[i]) hpm_r[i] <= hpm_r[i] + ONE_C;
      redirect_valid_r <= 1'b0;
      if (bus.trap_valid) begin
        mepc_r           <= {bus.trap_pc[XLEN-1:2], 2'b00};
        mcause_r         <= {bus.trap_is_int, {(XLEN-6){1'b0}}, bus.trap_code};
        mtval_r          <= bus.trap_is_int ? '0 : bus.trap_tval;
        mstatus_mpie_r   <= mstatus_mie_r;
        mstatus_mie_r    <= 1'b0;
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= trap_target_s;
      end else if (bus.mret_valid) begin
        mstatus_mie_r    <= mstatus_mpie_r;
        mstatus_mpie_r   <= 1'b1;
        redirect_valid_r <= 1'b1;
        redirect_pc_r    <= mepc_r;
      end else if (bus.wr_valid) begin
        // Later assignments here override the counter increments above
        case (bus.wa)
          12'h300: begin
            mstatus_mie_r  <= bus.wd[3];
            mstatus_mpie_r <= bus.wd[7];
            mstatus_fs_r   <= bus.wd[14:13];
          end
          12'h304: mie_r      <= {bus.wd[11], bus.wd[7], bus.wd[3]};
          12'h305: mtvec_r    <= {bus.wd[XLEN-1:2], 1'b0, bus.wd[0] & (VECTORED_EN != 0)};
          12'h340: mscratch_r <= bus.wd;
          12'h341: mepc_r     <= {bus.wd[XLEN-1:2], 2'b00};
          12'h342: mcause_r   <= bus.wd;
          12'h343: mtval_r    <= bus.wd;
          12'hB00: mcycle_r   <= bus.wd;
          12'hB02: minstret_r <= bus.wd;
          default: begin
            for (int i = 0; i < HPM_W; i++)
              if (i < NUM_HPM && bus.wa == hpm_addr(i)) hpm_r[i] <= bus.wd;
          end
        endcase
      end
    end
  end

  assign bus.rd             = rd_s;
  assign bus.rd_illegal     = rd_illegal_s;
  assign bus.int_req        = int_req_s;
  assign bus.int_code       = int_code_s;
  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
endmodule
